alu_execute_stage: RTL and testbench
====================================

Name: alu_execute_stage

Overview:
Execute-stage ALU of the pipelined MIPS. It sits directly downstream of the ALU control decoder and consumes its 4-bit operation code and JR flag together with the ID/EX operands. It computes the result and drives the registered EX/MEM-side outputs. Logic and arithmetic ops complete in one cycle. SLL/SRL run on a serial 1-bit-per-cycle shifter, and the block holds off upstream with busy while a shift is in progress.

Parameters:
DATA_WIDTH, 32, operand and result width
SHAMT_WIDTH, 5, shift-amount width; max shift is 2^SHAMT_WIDTH-1

Ports:
clk  input  1  pipeline clock, rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  operation presented on inputs this cycle
ALUOperation  input  4  op code from ALU control
Jr_Instruction  input  1  JR flag from ALU control
A  input  DATA_WIDTH  rs operand
B  input  DATA_WIDTH  rt operand or sign-extended immediate
shamt  input  SHAMT_WIDTH  shift amount (instruction bits 10:6)
hold  input  1  downstream (EX/MEM) stall; freezes outputs
busy  output  1  block cannot accept; upstream must keep inputs stable
out_valid  output  1  ALUResult/Zero/Jr_Out valid
ALUResult  output  DATA_WIDTH  registered result
Zero  output  1  registered (ALUResult == 0)
Jr_Out  output  1  registered copy of Jr_Instruction for accepted op

Behaviour:
- One clock. Reset is synchronous and active-high.
- Reset values: out_valid=0, ALUResult=0, Zero=1, Jr_Out=0, busy=0, state=IDLE, shift counter=0.
- Reset has priority over all other inputs. Reset asserted mid-shift discards the op, and the next cycle is IDLE.
- Accept condition: in_valid & state==IDLE & !hold. Inputs are sampled only on accept.
- busy = (state==SHIFT) | hold.
- Op codes and results, with arithmetic modulo 2^DATA_WIDTH and no overflow trap:
  - 0000 A+B
  - 0001 A&B
  - 0010 A|B
  - 0011 ~(A|B)
  - 0100 B<<shamt, logical
  - 0101 B>>shamt, logical with zero fill
  - 0110 {B[15:0],16'h0000}
  - 0111 A-B
  - 1001 (jump/JR) result 0
  - 1010 (memory map, LW/SW address) A+B
  - any other code: result 0
- States IDLE and SHIFT.
- IDLE, accept of a non-shift op, or a shift with shamt==0: result registered at the next edge, out_valid=1 for that cycle. Latency is 1 cycle.
- IDLE, accept of a shift with shamt>0:
  - Load shift register with B and counter with shamt; go to SHIFT.
  - out_valid=0 during SHIFT.
- SHIFT, each cycle: shift 1 bit in the selected direction and decrement the counter.
- SHIFT exit: when the counter reaches 1, the final shifted value is written to ALUResult at that edge, out_valid=1, and the block returns to IDLE.
- Total shift latency: shamt+1 cycles from the accept edge to out_valid.
- No accept without in_valid: out_valid drops to 0 the cycle after. ALUResult, Zero and Jr_Out retain their last values.
- hold=1: ALUResult, Zero, Jr_Out and out_valid are frozen. No new op is accepted. An in-progress SHIFT pauses (counter and shift register frozen) and resumes when hold drops.
- Zero and Jr_Out are registered in the same edge as ALUResult.
- in_valid while busy: ignored. Upstream is responsible for keeping the op stable until it is accepted.

Test Plan:
- Reset: assert reset for 2 cycles mid-stream -> out_valid=0, ALUResult=0, Zero=1, busy=0 on the edge after reset.
- Single-cycle ops: A=7, B=3 with 0000/0111/0001/0010 back-to-back -> out_valid each cycle, results 10, 4, 3, 7. Then A=B=5 with 0111 -> result 0, Zero=1.
- Wrap and misc ops: 0000 with A=32'hFFFFFFFF, B=1 -> 0, Zero=1. 0110 with B=32'h00001234 -> 32'h12340000. 0011 with A=B=0 -> 32'hFFFFFFFF. Op 1111 -> 0.
- Serial shifts:
  - 0100, B=1, shamt=31 -> busy for 31 cycles, out_valid on cycle 32, result 32'h80000000.
  - 0101, B=32'h80000000, shamt=4 -> 32'h08000000 after 5 cycles.
  - shamt=0 -> 1-cycle latency, result B.
- hold interaction: raise hold for 3 cycles during a shamt=8 shift -> outputs frozen and busy=1. Result appears 8+1+3 cycles after the accept edge. A new in_valid during hold is not accepted.
- Reset mid-shift and JR: reset in the 3rd cycle of a shamt=10 shift -> IDLE next cycle with no out_valid. Then op 1001 with Jr_Instruction=1 -> ALUResult=0, Zero=1, Jr_Out=1.

Source files
------------

// File: rtl/alu_execute_stage.sv
// Execute-stage ALU: single-cycle logic/arithmetic ops and a serial 1-bit-per-cycle shifter,
// with registered result/zero/JR outputs and a downstream hold that freezes the stage.
module alu_execute_stage #(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned SHAMT_WIDTH = 5
) (
   input  logic                   i_clk,
   input  logic                   i_reset,
   input  logic                   i_in_valid,
   input  logic [3:0]             i_alu_operation,
   input  logic                   i_jr_instruction,
   input  logic [DATA_WIDTH-1:0]  i_a,
   input  logic [DATA_WIDTH-1:0]  i_b,
   input  logic [SHAMT_WIDTH-1:0] i_shamt,
   input  logic                   i_hold,
   output logic                   o_busy,
   output logic                   o_out_valid,
   output logic [DATA_WIDTH-1:0]  o_alu_result,
   output logic                   o_zero,
   output logic                   o_jr_out
);

   localparam logic [3:0] OpAdd  = 4'b0000;
   localparam logic [3:0] OpAnd  = 4'b0001;
   localparam logic [3:0] OpOr   = 4'b0010;
   localparam logic [3:0] OpNor  = 4'b0011;
   localparam logic [3:0] OpSll  = 4'b0100;
   localparam logic [3:0] OpSrl  = 4'b0101;
   localparam logic [3:0] OpLui  = 4'b0110;
   localparam logic [3:0] OpSub  = 4'b0111;
   localparam logic [3:0] OpJump = 4'b1001;
   localparam logic [3:0] OpMem  = 4'b1010;

   typedef enum logic {StIdle, StShift} state_e;

   state_e                 r_state;
   state_e                 w_state_next;

   logic [DATA_WIDTH-1:0]  r_shreg;
   logic [SHAMT_WIDTH-1:0] r_cnt;
   logic                   r_left;
   logic                   r_jr_pend;
   logic [DATA_WIDTH-1:0]  r_result;
   logic                   r_zero;
   logic                   r_jr_out;
   logic                   r_out_valid;

   logic                   w_accept;
   logic                   w_is_shift;
   logic                   w_shift_start;
   logic                   w_shift_step;
   logic                   w_shift_done;
   logic [DATA_WIDTH-1:0]  w_alu_result;
   logic [DATA_WIDTH-1:0]  w_shifted;

   assign w_accept      = i_in_valid && (r_state == StIdle) && !i_hold;
   assign w_is_shift    = (i_alu_operation == OpSll) || (i_alu_operation == OpSrl);
   assign w_shift_start = w_accept && w_is_shift && (i_shamt != '0);
   assign w_shift_step  = (r_state == StShift) && !i_hold;
   assign w_shift_done  = w_shift_step && (r_cnt == SHAMT_WIDTH'(1));

   // Shift ops reach this path only with shamt==0, so the result is B unchanged.
   always_comb begin
      w_alu_result = '0;
      case (i_alu_operation)
         OpAdd, OpMem: w_alu_result = i_a + i_b;
         OpAnd:        w_alu_result = i_a & i_b;
         OpOr:         w_alu_result = i_a | i_b;
         OpNor:        w_alu_result = ~(i_a | i_b);
         OpSll, OpSrl: w_alu_result = i_b;
         OpLui:        w_alu_result = i_b << 16;
         OpSub:        w_alu_result = i_a - i_b;
         OpJump:       w_alu_result = '0;
         default:      w_alu_result = '0;
      endcase
   end

   always_comb begin
      if (r_left) begin
         w_shifted = {r_shreg[DATA_WIDTH-2:0], 1'b0};
      end else begin
         w_shifted = {1'b0, r_shreg[DATA_WIDTH-1:1]};
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         StIdle:  if (w_shift_start) w_state_next = StShift;
         StShift: if (w_shift_done) w_state_next = StIdle;
         default: w_state_next = StIdle;
      endcase
   end

   always_comb begin
      o_busy = (r_state == StShift) || i_hold;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_shreg     <= '0;
         r_cnt       <= '0;
         r_left      <= 1'b0;
         r_jr_pend   <= 1'b0;
         r_result    <= '0;
         r_zero      <= 1'b1;
         r_jr_out    <= 1'b0;
         r_out_valid <= 1'b0;
      end else if (w_shift_start) begin
         r_shreg     <= i_b;
         r_cnt       <= i_shamt;
         r_left      <= (i_alu_operation == OpSll);
         r_jr_pend   <= i_jr_instruction;
         r_out_valid <= 1'b0;
      end else if (w_accept) begin
         r_result    <= w_alu_result;
         r_zero      <= (w_alu_result == '0);
         r_jr_out    <= i_jr_instruction;
         r_out_valid <= 1'b1;
      end else if (w_shift_step) begin
         r_shreg <= w_shifted;
         r_cnt   <= r_cnt - SHAMT_WIDTH'(1);
         if (w_shift_done) begin
            r_result    <= w_shifted;
            r_zero      <= (w_shifted == '0);
            r_jr_out    <= r_jr_pend;
            r_out_valid <= 1'b1;
         end
      end else if (!i_hold) begin
         // Idle with nothing accepted: only the valid flag drops, data is retained.
         r_out_valid <= 1'b0;
      end
   end

   assign o_out_valid  = r_out_valid;
   assign o_alu_result = r_result;
   assign o_zero       = r_zero;
   assign o_jr_out     = r_jr_out;

endmodule

// File: tb/tb_alu_execute_stage.sv
// Self-checking bench for alu_execute_stage: directed steps plus random ops checked
// against an arithmetic reference of results and shift latency.
module tb_alu_execute_stage;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic [3:0]  op;
   logic        jr;
   logic [31:0] a;
   logic [31:0] b;
   logic [4:0]  shamt;
   logic        hold;
   logic        busy;
   logic        out_valid;
   logic [31:0] result;
   logic        zero;
   logic        jr_out;

   int n_checks = 0;
   int n_err    = 0;

   alu_execute_stage #(
      .DATA_WIDTH  (32),
      .SHAMT_WIDTH (5)
   ) u_dut (
      .i_clk            (clk),
      .i_reset          (reset),
      .i_in_valid       (in_valid),
      .i_alu_operation  (op),
      .i_jr_instruction (jr),
      .i_a              (a),
      .i_b              (b),
      .i_shamt          (shamt),
      .i_hold           (hold),
      .o_busy           (busy),
      .o_out_valid      (out_valid),
      .o_alu_result     (result),
      .o_zero           (zero),
      .o_jr_out         (jr_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [31:0] ref_alu(input logic [3:0] f_op, input logic [31:0] f_a,
                                           input logic [31:0] f_b, input logic [4:0] f_sh);
      case (f_op)
         4'd0, 4'd10: return f_a + f_b;
         4'd1:        return f_a & f_b;
         4'd2:        return f_a | f_b;
         4'd3:        return ~(f_a | f_b);
         4'd4:        return f_b << f_sh;
         4'd5:        return f_b >> f_sh;
         4'd6:        return f_b * 32'd65536;
         4'd7:        return f_a - f_b;
         default:     return 32'd0;
      endcase
   endfunction

   task automatic chk(input string tag, input string what, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s.%s observed=%0h expected=%0h", tag, what, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int cycles);
      reset = 1'b1;
      repeat (cycles) step();
      reset = 1'b0;
   endtask

   // Present one op, wait for its result and compare result, flags and latency.
   // Hold is raised in cycle hold_at (counted from the accept edge) for hold_len cycles.
   task automatic run_op(input string tag, input logic [3:0] t_op, input logic t_jr,
                         input logic [31:0] t_a, input logic [31:0] t_b, input logic [4:0] t_sh,
                         input int hold_at, input int hold_len);
      logic [31:0] exp_res;
      int          exp_lat;
      int          c;
      exp_res = ref_alu(t_op, t_a, t_b, t_sh);
      exp_lat = (((t_op == 4'd4) || (t_op == 4'd5)) ? int'(t_sh) : 0) + 1 + hold_len;
      op       = t_op;
      jr       = t_jr;
      a        = t_a;
      b        = t_b;
      shamt    = t_sh;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      c = 1;
      while (!out_valid && c < 200) begin
         if (c == hold_at) hold = 1'b1;
         if (c == hold_at + hold_len) hold = 1'b0;
         chk(tag, "busy", {31'd0, busy}, 32'd1);
         step();
         c++;
      end
      hold = 1'b0;
      chk(tag, "latency", c, exp_lat);
      chk(tag, "out_valid", {31'd0, out_valid}, 32'd1);
      chk(tag, "result", result, exp_res);
      chk(tag, "zero", {31'd0, zero}, {31'd0, exp_res == 32'd0});
      chk(tag, "jr_out", {31'd0, jr_out}, {31'd0, t_jr});
   endtask

   initial begin
      logic [31:0] last;
      int          seen;
      reset    = 1'b1;
      in_valid = 1'b0;
      op       = 4'd0;
      jr       = 1'b0;
      a        = 32'd0;
      b        = 32'd0;
      shamt    = 5'd0;
      hold     = 1'b0;

      do_reset(2);
      chk("rst0", "out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst0", "result", result, 32'd0);
      chk("rst0", "zero", {31'd0, zero}, 32'd1);
      chk("rst0", "busy", {31'd0, busy}, 32'd0);
      chk("rst0", "jr_out", {31'd0, jr_out}, 32'd0);

      // Back-to-back single-cycle ops
      run_op("add", 4'b0000, 1'b0, 32'd7, 32'd3, 5'd0, 0, 0);
      run_op("sub", 4'b0111, 1'b0, 32'd7, 32'd3, 5'd0, 0, 0);
      run_op("and", 4'b0001, 1'b0, 32'd7, 32'd3, 5'd0, 0, 0);
      run_op("or", 4'b0010, 1'b0, 32'd7, 32'd3, 5'd0, 0, 0);
      run_op("sub0", 4'b0111, 1'b0, 32'd5, 32'd5, 5'd0, 0, 0);

      step();
      chk("idle", "out_valid", {31'd0, out_valid}, 32'd0);
      chk("idle", "result", result, 32'd0);
      chk("idle", "zero", {31'd0, zero}, 32'd1);

      // Reset mid-stream while a valid nonzero result is showing
      run_op("pre_rst", 4'b0000, 1'b1, 32'd2, 32'd3, 5'd0, 0, 0);
      do_reset(2);
      chk("rst1", "out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst1", "result", result, 32'd0);
      chk("rst1", "zero", {31'd0, zero}, 32'd1);
      chk("rst1", "busy", {31'd0, busy}, 32'd0);
      chk("rst1", "jr_out", {31'd0, jr_out}, 32'd0);

      run_op("wrap", 4'b0000, 1'b0, 32'hFFFF_FFFF, 32'd1, 5'd0, 0, 0);
      run_op("lui", 4'b0110, 1'b0, 32'hDEAD_BEEF, 32'h0000_1234, 5'd0, 0, 0);
      run_op("nor", 4'b0011, 1'b0, 32'd0, 32'd0, 5'd0, 0, 0);
      run_op("op15", 4'b1111, 1'b0, 32'h1111_2222, 32'h3333_4444, 5'd0, 0, 0);
      run_op("mem", 4'b1010, 1'b0, 32'h0000_1000, 32'hFFFF_FFFC, 5'd0, 0, 0);

      run_op("sll31", 4'b0100, 1'b0, 32'd0, 32'd1, 5'd31, 0, 0);
      run_op("srl4", 4'b0101, 1'b0, 32'd0, 32'h8000_0000, 5'd4, 0, 0);
      run_op("sll0", 4'b0100, 1'b0, 32'd0, 32'h0000_ABCD, 5'd0, 0, 0);
      run_op("hold_shift", 4'b0100, 1'b1, 32'd0, 32'h0000_00F1, 5'd8, 3, 3);

      // Hold while idle: outputs frozen and the presented op is never accepted
      last     = result;
      hold     = 1'b1;
      op       = 4'b0000;
      a        = 32'd1;
      b        = 32'd1;
      in_valid = 1'b1;
      step();
      chk("hold_idle", "out_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_idle", "result", result, last);
      chk("hold_idle", "busy", {31'd0, busy}, 32'd1);
      step();
      chk("hold_idle2", "result", result, last);
      in_valid = 1'b0;
      hold     = 1'b0;
      step();
      chk("hold_rel", "out_valid", {31'd0, out_valid}, 32'd0);
      chk("hold_rel", "result", result, last);

      // Reset in the 3rd cycle of a shamt=10 shift
      op       = 4'b0100;
      jr       = 1'b1;
      b        = 32'd3;
      shamt    = 5'd10;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      step();
      chk("rst_shift", "busy_before", {31'd0, busy}, 32'd1);
      do_reset(1);
      chk("rst_shift", "out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_shift", "busy", {31'd0, busy}, 32'd0);
      chk("rst_shift", "result", result, 32'd0);
      chk("rst_shift", "zero", {31'd0, zero}, 32'd1);
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (out_valid || busy) seen++;
      end
      chk("rst_shift", "late_activity", seen, 32'd0);

      run_op("jr", 4'b1001, 1'b1, 32'h0040_0010, 32'h1234_5678, 5'd0, 0, 0);

      for (int i = 0; i < 40; i++) begin
         logic [3:0]  r_op;
         logic [4:0]  r_sh;
         int          r_hl;
         r_op = 4'($urandom_range(0, 15));
         r_sh = 5'($urandom_range(0, 9));
         r_hl = 0;
         if (((r_op == 4'd4) || (r_op == 4'd5)) && (r_sh != 5'd0)) r_hl = $urandom_range(0, 2);
         run_op("rand", r_op, 1'($urandom), $urandom, $urandom, r_sh, 1, r_hl);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
